// File: rtl/router_fsm.sv
// router_fsm: control FSM for the 1x3 router input path. Decodes the header
// address, sequences header/payload/parity/check phases and drives the
// register strobes, FIFO write enable and the busy back-pressure flag.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam int unsigned AddrW = 2;

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [AddrW-1:0] addr_q;
  logic [AddrW-1:0] empty_addr;
  logic             fifo_empty_sel;
  logic             soft_reset_sel;

  // Empty flag of the destination: header bits while decoding, latched address afterwards.
  always_comb begin
    empty_addr     = (state_q == DA) ? data_in : addr_q;
    fifo_empty_sel = 1'b0;
    case (empty_addr)
      2'd0:    fifo_empty_sel = fifo_empty_0;
      2'd1:    fifo_empty_sel = fifo_empty_1;
      2'd2:    fifo_empty_sel = fifo_empty_2;
      default: fifo_empty_sel = 1'b0;
    endcase
  end

  // Soft reset of the latched destination only; other FIFOs' timeouts are ignored.
  always_comb begin
    soft_reset_sel = 1'b0;
    case (addr_q)
      2'd0:    soft_reset_sel = soft_reset_0;
      2'd1:    soft_reset_sel = soft_reset_1;
      2'd2:    soft_reset_sel = soft_reset_2;
      default: soft_reset_sel = 1'b0;
    endcase
  end

  // Next-state logic; a soft reset outside DA overrides every other transition.
  always_comb begin
    state_d = state_q;
    if ((state_q != DA) && soft_reset_sel) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA: begin
          if (pkt_valid && (data_in != 2'd3)) begin
            state_d = fifo_empty_sel ? LFD : WTE;
          end
        end
        LFD: state_d = LD;
        LD: begin
          if (fifo_full) begin
            state_d = FFS;
          end else if (!pkt_valid) begin
            state_d = LP;
          end
        end
        FFS: begin
          if (!fifo_full) begin
            state_d = LAF;
          end
        end
        LAF: begin
          if (parity_done) begin
            state_d = DA;
          end else if (low_pkt_valid) begin
            state_d = LP;
          end else begin
            state_d = LD;
          end
        end
        LP:  state_d = CPE;
        CPE: state_d = fifo_full ? FFS : DA;
        WTE: begin
          if (fifo_empty_sel) begin
            state_d = LFD;
          end
        end
        default: state_d = DA;
      endcase
    end
  end

  // State, address latch and Moore outputs registered from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= DA;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == DA) && pkt_valid) begin
        addr_q <= data_in;
      end
      detect_add    <= (state_d == DA);
      lfd_state     <= (state_d == LFD);
      ld_state      <= (state_d == LD);
      laf_state     <= (state_d == LAF);
      full_state    <= (state_d == FFS);
      rst_int_reg   <= (state_d == CPE);
      write_enb_reg <= (state_d == LD) || (state_d == LP) || (state_d == LAF);
      busy          <= (state_d == LFD) || (state_d == FFS) || (state_d == LAF) ||
                       (state_d == LP)  || (state_d == CPE) || (state_d == WTE);
    end
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine for the 1x3 router input path.
- Decodes the 2-bit destination address in the packet header and sequences the router register datapath through header, payload, parity and parity-check phases.
- Drives the register's state strobes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Drives the FIFO write enable and the `busy` back-pressure flag seen by the packet source.

Parameters:
- None. State encoding is internal; one-hot or binary are both acceptable.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- resetn  input  1  asynchronous active-low reset
- pkt_valid  input  1  packet source: byte on data_in is part of a packet; deasserted with the parity byte
- data_in  input  2  header bits [1:0]: destination address (0,1,2 valid; 3 invalid)
- fifo_full  input  1  destination FIFO full, from the synchroniser
- fifo_empty_0  input  1  FIFO 0 empty
- fifo_empty_1  input  1  FIFO 1 empty
- fifo_empty_2  input  1  FIFO 2 empty
- soft_reset_0  input  1  FIFO 0 read-timeout soft reset
- soft_reset_1  input  1  FIFO 1 read-timeout soft reset
- soft_reset_2  input  1  FIFO 2 read-timeout soft reset
- parity_done  input  1  router register: parity byte captured
- low_pkt_valid  input  1  router register: pkt_valid fell while the FIFO was full
- write_enb_reg  output  1  write enable to the FIFO/synchroniser
- detect_add  output  1  in DECODE_ADDRESS
- lfd_state  output  1  in LOAD_FIRST_DATA
- ld_state  output  1  in LOAD_DATA
- laf_state  output  1  in LOAD_AFTER_FULL
- full_state  output  1  in FIFO_FULL_STATE
- rst_int_reg  output  1  in CHECK_PARITY_ERROR
- busy  output  1  source must hold the current byte

Behaviour:

States:
- DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE).

Reset:
- resetn=0 forces DA immediately, independent of clock.
- Address latch resets to 0.
- Outputs in reset: detect_add=1; all other strobes, write_enb_reg and busy are 0.
- Reset asserted mid-packet abandons the packet; no partial completion.

Address latch:
- addr_q <= data_in whenever state==DA and pkt_valid=1.
- Held in all other states.
- fifo_empty_sel and soft_reset_sel select the FIFO given by addr_q. In DA, fifo_empty_sel is selected by data_in directly.

Transitions (evaluated each rising edge):
- DA:
  - pkt_valid=1, data_in<3, selected FIFO empty -> LFD.
  - pkt_valid=1, data_in<3, selected FIFO not empty -> WTE.
  - data_in==3 or pkt_valid=0 -> stay in DA. An invalid address is dropped.
- LFD: -> LD unconditionally. Exactly one cycle.
- LD:
  - fifo_full=1 -> FFS. fifo_full has priority over pkt_valid.
  - else pkt_valid=0 -> LP.
  - else stay in LD.
- FFS: fifo_full=0 -> LAF; else stay.
- LAF:
  - parity_done=1 -> DA.
  - else low_pkt_valid=1 -> LP.
  - else -> LD.
- LP: -> CPE unconditionally.
- CPE: fifo_full=1 -> FFS; else -> DA.
- WTE: fifo_empty of addr_q =1 -> LFD; else stay.

Soft reset:
- In any state other than DA, soft_reset_sel=1 forces DA at the next edge.
- Soft reset has priority over every other transition.
- Soft resets on non-selected FIFOs are ignored.

Outputs (Moore, decoded from current state only; no output depends combinationally on inputs):
- detect_add=DA, lfd_state=LFD, ld_state=LD, laf_state=LAF, full_state=FFS, rst_int_reg=CPE.
- write_enb_reg = LD | LP | LAF.
- busy = LFD | FFS | LAF | LP | CPE | WTE.
- busy=0 only in DA and LD.

Latency:
- Header accepted in DA, LFD on the next cycle.
- Minimum packet with N payload bytes: 1 DA + 1 LFD + N LD + 1 LP + 1 CPE cycles.

Test Plan:
1. Good packet: resetn pulse; header {6'd8,2'b01}, fifo_empty_1=1, pkt_valid held 9 bytes -> DA 1 cycle, LFD 1, LD 8 (write_enb_reg=1, busy=0), LP 1 (write_enb_reg=1, busy=1), CPE 1 (rst_int_reg=1), back to DA.
2. Busy destination: header addr 2'b10, fifo_empty_2=0 for 3 cycles then 1 -> WTE for 3 cycles with busy=1 and write_enb_reg=0, then LFD.
3. FIFO full: fifo_full=1 on 3rd LD cycle for 4 cycles, parity_done=0, low_pkt_valid=0 -> FFS 4 cycles (full_state=1, write_enb_reg=0, busy=1), LAF 1 cycle, then LD resumes.
4. Full at end: LAF with low_pkt_valid=1 -> LP then CPE. Separate run: LAF with parity_done=1 -> DA directly. Separate run: CPE with fifo_full=1 -> FFS.
5. Soft reset: packet to addr 0 in LD, pulse soft_reset_1 -> no effect; pulse soft_reset_0 -> DA next edge, detect_add=1, busy=0.
6. Invalid address and async reset: header data_in=2'b11, pkt_valid=1 -> stays in DA 5 cycles. Then resetn=0 mid-LD between clock edges -> detect_add=1 and ld_state=0 before the next edge.
